// File: rtl/uart_mmio_bridge.sv
// rtl/uart_mmio_bridge.sv - CPU MMIO slave bridging loads/stores to the simulation UART sink.
// Stores to TX become single-cycle FIFO pushes; STAT loads go through a one-cycle-delayed status handshake.
module uart_mmio_bridge #(
  parameter int ADDR_W   = 5,
  parameter int FULL_BIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_req_ready,
  output logic [31:0]       mem_rdata,
  output logic              mem_rdata_valid,
  input  logic              mem_rdata_ready,
  output logic              uart_write_fifo,
  output logic [7:0]        uart_write_data,
  output logic              uart_read_state,
  input  logic              uart_read_ok,
  input  logic [31:0]       uart_read_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [2:0] OFF_TX    = 3'd1;
  localparam logic [2:0] OFF_STAT  = 3'd2;
  localparam logic [2:0] OFF_TXCNT = 3'd4;

  state_t      state_q;
  logic [31:0] tx_count_q;
  logic [31:0] mem_rdata_q;
  logic        mem_rdata_valid_q;
  logic        uart_write_fifo_q;
  logic [7:0]  uart_write_data_q;
  logic        uart_read_state_q;
  logic [2:0]  offset;
  logic        unused_bits;

  assign offset          = mem_addr[4:2];
  assign mem_req_ready   = (state_q == IDLE);
  assign mem_rdata       = mem_rdata_q;
  assign mem_rdata_valid = mem_rdata_valid_q;
  assign uart_write_fifo = uart_write_fifo_q;
  assign uart_write_data = uart_write_data_q;
  assign uart_read_state = uart_read_state_q;
  assign unused_bits     = ^{mem_addr[1:0], mem_wdata[31:8], mem_wstrb[3:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      tx_count_q        <= 32'd0;
      mem_rdata_q       <= 32'd0;
      mem_rdata_valid_q <= 1'b0;
      uart_write_fifo_q <= 1'b0;
      uart_write_data_q <= 8'd0;
      uart_read_state_q <= 1'b0;
    end else begin
      uart_write_fifo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A simultaneous load is dropped when a store is present; the CPU reissues it.
          if (mem_write) begin
            if (offset == OFF_TX && mem_wstrb[0]) begin
              uart_write_data_q <= mem_wdata[7:0];
              state_q           <= WR_WAIT;
            end
          end else if (mem_read) begin
            if (offset == OFF_STAT) begin
              uart_read_state_q <= 1'b1;
              state_q           <= RD_REQ;
            end else begin
              mem_rdata_q       <= (offset == OFF_TXCNT) ? tx_count_q : 32'd0;
              mem_rdata_valid_q <= 1'b1;
              state_q           <= RESP;
            end
          end
        end
        WR_WAIT: begin
          if (!uart_read_data[FULL_BIT]) begin
            uart_write_fifo_q <= 1'b1;
            tx_count_q        <= tx_count_q + 32'd1;
            state_q           <= IDLE;
          end
        end
        RD_REQ: begin
          uart_read_state_q <= 1'b0;
          state_q           <= RD_WAIT;
        end
        RD_WAIT: begin
          if (uart_read_ok) begin
            mem_rdata_q       <= uart_read_data;
            mem_rdata_valid_q <= 1'b1;
            state_q           <= RESP;
          end
        end
        RESP: begin
          if (mem_rdata_ready) begin
            mem_rdata_valid_q <= 1'b0;
            state_q           <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb/tb_uart_mmio_bridge.sv - Directed bench with a timestamp-based model of the UART MMIO bridge.
module tb_uart_mmio_bridge;

  localparam int BIG = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  mem_addr = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_req_ready;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_rdata_ready = 1'b1;
  logic        uart_write_fifo;
  logic [7:0]  uart_write_data;
  logic        uart_read_state;
  logic        uart_read_ok = 1'b0;
  logic [31:0] uart_read_data = '0;

  always #5 clk = ~clk;

  uart_mmio_bridge #(.ADDR_W(5), .FULL_BIT(3)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready),
    .uart_write_fifo(uart_write_fifo), .uart_write_data(uart_write_data),
    .uart_read_state(uart_read_state), .uart_read_ok(uart_read_ok), .uart_read_data(uart_read_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Status stub: read_ok is read_state delayed by one cycle.
  logic rs_prev = 1'b0;
  always @(negedge clk) begin
    uart_read_ok = rs_prev;
    rs_prev = (uart_read_state === 1'b1);
  end

  // Model: tracks when the bridge is free again and what each transaction must produce.
  bit          armed = 0;
  int          free_at = 0;
  bit          st_pend = 0;
  int          stat_at = -1;
  logic [31:0] m_cnt = '0;
  logic        e_push = 0, e_rs = 0, e_valid = 0;
  logic [7:0]  e_wdata = '0;
  logic [31:0] e_rdata = '0;

  always @(posedge clk) begin
    int off;
    cyc = cyc + 1;
    if (reset) begin
      armed = 1; free_at = cyc; st_pend = 0; stat_at = -1; m_cnt = '0;
      e_push = 0; e_rs = 0; e_valid = 0; e_wdata = '0; e_rdata = '0;
    end else if (armed) begin
      e_push = 0;
      e_rs = 0;
      if (e_valid) begin
        if (mem_rdata_ready) begin
          e_valid = 0;
          free_at = cyc;
        end
      end else if (stat_at == cyc) begin
        e_rdata = uart_read_data;
        e_valid = 1;
      end else if (st_pend) begin
        if (!uart_read_data[3]) begin
          e_push = 1; m_cnt = m_cnt + 1; st_pend = 0; free_at = cyc;
        end
      end else if (cyc - 1 >= free_at && (mem_write || mem_read)) begin
        off = int'(mem_addr[4:2]);
        if (mem_write) begin
          if (off == 1 && mem_wstrb[0]) begin
            st_pend = 1; e_wdata = mem_wdata[7:0]; free_at = BIG;
          end
        end else begin
          free_at = BIG;
          if (off == 2) begin
            e_rs = 1; stat_at = cyc + 2;
          end else begin
            e_rdata = (off == 4) ? m_cnt : 32'd0;
            e_valid = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_req_ready", {31'd0, mem_req_ready}, {31'd0, (cyc >= free_at)});
      chk("model_write_fifo", {31'd0, uart_write_fifo}, {31'd0, e_push});
      chk("model_write_data", {24'd0, uart_write_data}, {24'd0, e_wdata});
      chk("model_read_state", {31'd0, uart_read_state}, {31'd0, e_rs});
      chk("model_rdata_valid", {31'd0, mem_rdata_valid}, {31'd0, e_valid});
      chk("model_rdata", mem_rdata, e_rdata);
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (mem_req_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic store(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    wait_ready();
    mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic load(input logic [4:0] a);
    wait_ready();
    mem_addr = a; mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [4:0] zero_offs [6] = '{5'h00, 5'h04, 5'h0C, 5'h14, 5'h18, 5'h1C};

  initial begin
    do_reset();
    idle(5);
    chk("rst_req_ready", {31'd0, mem_req_ready}, 32'd1);
    chk("rst_rdata_valid", {31'd0, mem_rdata_valid}, 32'd0);
    chk("rst_write_fifo", {31'd0, uart_write_fifo}, 32'd0);
    chk("rst_read_state", {31'd0, uart_read_state}, 32'd0);
    load(5'h10);
    chk("rst_txcnt_valid", {31'd0, mem_rdata_valid}, 32'd1);
    chk("rst_txcnt", mem_rdata, 32'h0000_0000);

    // Single store, FIFO not full: push in t+2.
    uart_read_data = 32'h0;
    store(5'h04, 32'h0000_0041, 4'hF);
    chk("st41_ready_t1", {31'd0, mem_req_ready}, 32'd0);
    chk("st41_push_t1", {31'd0, uart_write_fifo}, 32'd0);
    @(negedge clk);
    chk("st41_push_t2", {31'd0, uart_write_fifo}, 32'd1);
    chk("st41_data_t2", {24'd0, uart_write_data}, 32'h41);
    chk("st41_ready_t2", {31'd0, mem_req_ready}, 32'd1);
    @(negedge clk);
    chk("st41_push_t3", {31'd0, uart_write_fifo}, 32'd0);

    // FIFO full for 10 cycles stalls the store.
    uart_read_data = 32'h0000_0008;
    store(5'h04, 32'h0000_0042, 4'hF);
    for (int i = 1; i <= 10; i++) begin
      chk("full_ready", {31'd0, mem_req_ready}, 32'd0);
      chk("full_push", {31'd0, uart_write_fifo}, 32'd0);
      if (i == 10) uart_read_data = 32'h0;
      @(negedge clk);
    end
    chk("full_push_after", {31'd0, uart_write_fifo}, 32'd1);
    chk("full_data_after", {24'd0, uart_write_data}, 32'h42);
    @(negedge clk);
    chk("full_single_push", {31'd0, uart_write_fifo}, 32'd0);

    // Ignored stores.
    store(5'h04, 32'h0000_0099, 4'h0);
    chk("nostrb_ready", {31'd0, mem_req_ready}, 32'd1);
    chk("nostrb_push", {31'd0, uart_write_fifo}, 32'd0);
    store(5'h0C, 32'h0000_0077, 4'hF);
    chk("ctrl_ready", {31'd0, mem_req_ready}, 32'd1);
    store(5'h10, 32'h0000_1234, 4'hF);
    load(5'h10);
    chk("txcnt_two", mem_rdata, 32'h0000_0002);

    // Store and load together: store wins (ignored TXCNT store), load dropped.
    wait_ready();
    mem_addr = 5'h10; mem_write = 1'b1; mem_read = 1'b1;
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b0;
    chk("both_no_valid", {31'd0, mem_rdata_valid}, 32'd0);
    chk("both_ready", {31'd0, mem_req_ready}, 32'd1);

    foreach (zero_offs[j]) begin
      load(zero_offs[j]);
      chk("zero_load", mem_rdata, 32'h0);
    end

    // Three stores after reset, then held TXCNT response.
    do_reset();
    for (int b = 0; b < 3; b++) store(5'h04, 32'h61 + 32'(b), 4'hF);
    mem_rdata_ready = 1'b0;
    load(5'h10);
    for (int i = 1; i <= 6; i++) begin
      chk("hold_valid", {31'd0, mem_rdata_valid}, 32'd1);
      chk("hold_data", mem_rdata, 32'h0000_0003);
      if (i == 6) mem_rdata_ready = 1'b1;
      @(negedge clk);
    end
    chk("hold_valid_drop", {31'd0, mem_rdata_valid}, 32'd0);

    // Status read.
    uart_read_data = 32'h0000_0008;
    load(5'h08);
    chk("stat_rs_t1", {31'd0, uart_read_state}, 32'd1);
    @(negedge clk);
    chk("stat_rs_t2", {31'd0, uart_read_state}, 32'd0);
    chk("stat_valid_t2", {31'd0, mem_rdata_valid}, 32'd0);
    @(negedge clk);
    chk("stat_valid_t3", {31'd0, mem_rdata_valid}, 32'd1);
    chk("stat_data_t3", mem_rdata, 32'h0000_0008);
    @(negedge clk);
    chk("stat_valid_t4", {31'd0, mem_rdata_valid}, 32'd0);

    // Reset while waiting on a full FIFO abandons the store.
    store(5'h04, 32'h0000_0055, 4'hF);
    reset = 1'b1;
    uart_read_data = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw_ready", {31'd0, mem_req_ready}, 32'd1);
    chk("rstw_push", {31'd0, uart_write_fifo}, 32'd0);
    @(negedge clk);
    chk("rstw_push_next", {31'd0, uart_write_fifo}, 32'd0);
    chk("rstw_wdata", {24'd0, uart_write_data}, 32'h0);
    load(5'h10);
    chk("rstw_txcnt", mem_rdata, 32'h0000_0000);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
